// File: rtl/debug_latch_tx.sv
// debug_latch_tx: transmit side of the MIPS debug unit.
// Snapshots one pipeline latch, sends it LSB byte first, then the ready char.
module debug_latch_tx #(
    parameter int         IF_ID_SIZE  = 32,
    parameter int         ID_EX_SIZE  = 129,
    parameter int         EX_MEM_SIZE = 77,
    parameter int         MEM_WB_SIZE = 71,
    parameter logic [7:0] READY_CHAR  = 8'h52,
    parameter int         MAX_BYTES   = 17
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [1:0]             i_sel,
    input  logic [IF_ID_SIZE-1:0]  i_if_id,
    input  logic [ID_EX_SIZE-1:0]  i_id_ex,
    input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
    input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
    input  logic                   i_tx_done,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BUF_W = MAX_BYTES * 8;
    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] IF_ID_N  = CNT_W'((IF_ID_SIZE + 7) / 8);
    localparam logic [CNT_W-1:0] ID_EX_N  = CNT_W'((ID_EX_SIZE + 7) / 8);
    localparam logic [CNT_W-1:0] EX_MEM_N = CNT_W'((EX_MEM_SIZE + 7) / 8);
    localparam logic [CNT_W-1:0] MEM_WB_N = CNT_W'((MEM_WB_SIZE + 7) / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_TRAIL,
        S_TWAIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [BUF_W-1:0] shbuf;
    logic [CNT_W-1:0] nbytes;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_nxt;
    logic [BUF_W-1:0] snap;
    logic [CNT_W-1:0] snap_n;

    assign idx_nxt = idx + CNT_W'(1);

    // Zero-extended image of the selected latch and its byte count.
    always_comb begin
        snap   = '0;
        snap_n = IF_ID_N;
        case (i_sel)
            2'd0: begin
                snap   = BUF_W'(i_if_id);
                snap_n = IF_ID_N;
            end
            2'd1: begin
                snap   = BUF_W'(i_id_ex);
                snap_n = ID_EX_N;
            end
            2'd2: begin
                snap   = BUF_W'(i_ex_mem);
                snap_n = EX_MEM_N;
            end
            default: begin
                snap   = BUF_W'(i_mem_wb);
                snap_n = MEM_WB_N;
            end
        endcase
    end

    // Dump sequencer; the buffer shifts right so the next byte is always [7:0].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            shbuf      <= '0;
            nbytes     <= '0;
            idx        <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        shbuf  <= snap;
                        nbytes <= snap_n;
                        o_busy <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    idx        <= '0;
                    o_tx_data  <= shbuf[7:0];
                    shbuf      <= shbuf >> 8;
                    o_tx_start <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        idx        <= idx_nxt;
                        o_tx_start <= 1'b1;
                        if (idx_nxt == nbytes) begin
                            o_tx_data <= READY_CHAR;
                            state     <= S_TRAIL;
                        end else begin
                            o_tx_data <= shbuf[7:0];
                            shbuf     <= shbuf >> 8;
                            state     <= S_SEND;
                        end
                    end
                end
                S_TRAIL: begin
                    state <= S_TWAIT;
                end
                S_TWAIT: begin
                    if (i_tx_done) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
